// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fq_entry_t : one buffered fetch result, {pc, instr}
//   INSN_BYTES : address increment between sequential fetches
//   NOP_INSN   : canonical RV32I nop (addi x0, x0, 0)
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam int unsigned INSN_BYTES = 4;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle of the fetch queue.
//   redirect_valid/redirect_pc : taken branch/jump from EX
//   imem_req_*                 : fetch request channel to instruction memory
//   imem_rsp_*                 : in-order response channel, no backpressure
//   dec_*                      : head of queue towards the IF/ID register
// Modport master is the fetch queue itself; slave is its environment.
interface fetch_queue_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_pc, dec_instr,
        input  dec_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_pc, dec_instr,
        output dec_ready
    );

endinterface

// File: rtl/fq_fifo.sv
// Synchronous FIFO with a registered head entry.
//   clk, rst_n : clock, synchronous active-high reset (rst_n = 1 resets)
//   clear      : empties the FIFO; head register keeps its last value
//   push/push_data, pop : write at tail / remove head (pop ignored when empty)
//   count      : number of stored entries
//   head       : registered copy of the oldest entry; holds last value when empty
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fq_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output T                         head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    T               mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, rd_next;
    logic [CntW-1:0] count_q, cnt_after_pop;
    T               head_q, head_d;
    logic           pop_eff;

    always_comb begin
        pop_eff       = pop && (count_q != '0);
        rd_next       = rd_ptr_q + PtrW'(pop_eff);
        cnt_after_pop = count_q - CntW'(pop_eff);
        // Head is rebuilt every cycle so the consumer sees a flop, never the response bus.
        if (cnt_after_pop != '0) begin
            head_d = mem_q[rd_next];
        end else if (push) begin
            head_d = push_data;
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !rst_n) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_next;
            wr_ptr_q <= wr_ptr_q + PtrW'(push);
            count_q  <= cnt_after_pop + CntW'(push);
            head_q   <= head_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end feeding IF/ID.
//   clk   : clock
//   rst_n : synchronous reset, asserted HIGH
//   fq    : fetch_queue_if.master (redirect, imem request/response, decode handshake)
// Optional build macro FETCH_QUEUE_STATS_EN adds:
//   stat_empty_cyc : cycles where decode was ready but nothing was valid (saturating)
//   stat_redirects : number of redirects seen (saturating)
// Requests are credit-limited so every kept response always has a free queue slot.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUTS = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master fq
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]   stat_empty_cyc,
    output logic [31:0]   stat_redirects
`endif
);

    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned OutsW = $clog2(MAX_OUTS + 1);
    localparam int unsigned SumW  = ((CntW > OutsW) ? CntW : OutsW) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [OutsW-1:0] outs_q, outs_d, discard_q, discard_d;
    logic [CntW-1:0]  count;
    logic [SumW-1:0]  inflight;
    logic             req_fire, rsp_keep, pop;
    fq_entry_t        head, push_data;

    assign target   = fq.redirect_pc & ~32'h3;
    assign inflight = SumW'(count) + SumW'(outs_q);

    assign fq.imem_req_valid = !rst_n && !fq.redirect_valid &&
                               (outs_q < OutsW'(MAX_OUTS)) && (inflight < SumW'(DEPTH));
    assign fq.imem_req_addr  = fetch_pc_q;
    assign fq.dec_valid      = (count != '0);
    assign fq.dec_pc         = head.pc;
    assign fq.dec_instr      = head.instr;

    assign req_fire  = fq.imem_req_valid && fq.imem_req_ready;
    // Responses owed to a squashed path, or arriving with a redirect, never enter the queue.
    assign rsp_keep  = fq.imem_rsp_valid && (discard_q == '0) && !fq.redirect_valid;
    assign pop       = fq.dec_valid && fq.dec_ready;
    assign push_data = '{pc: rsp_pc_q, instr: fq.imem_rsp_data};

    always_comb begin
        outs_d = outs_q + OutsW'(req_fire) - OutsW'(fq.imem_rsp_valid);
        if (fq.redirect_valid) begin
            discard_d  = outs_d;
            fetch_pc_d = target;
            rsp_pc_d   = target;
        end else begin
            discard_d  = discard_q;
            if (fq.imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            fetch_pc_d = fetch_pc_q + (req_fire ? 32'(INSN_BYTES) : 32'h0);
            rsp_pc_d   = rsp_pc_q + (rsp_keep ? 32'(INSN_BYTES) : 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outs_q     <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outs_q     <= outs_d;
            discard_q  <= discard_d;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .T     (fq_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (fq.redirect_valid),
        .push      (rsp_keep),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_empty_q, stat_redir_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stat_empty_q <= '0;
            stat_redir_q <= '0;
        end else begin
            if (fq.dec_ready && !fq.dec_valid && (stat_empty_q != '1)) begin
                stat_empty_q <= stat_empty_q + 32'd1;
            end
            if (fq.redirect_valid && (stat_redir_q != '1)) begin
                stat_redir_q <= stat_redir_q + 32'd1;
            end
        end
    end

    assign stat_empty_cyc = stat_empty_q;
    assign stat_redirects = stat_redir_q;
`endif

    rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst_n) fq.imem_rsp_valid |-> (outs_q != '0));
    no_push_when_full: assert property (
        @(posedge clk) disable iff (rst_n) rsp_keep |-> (count < CntW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUTS = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if bus ();

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_empty_cyc, stat_redirects;
`endif

    fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUTS (MAX_OUTS),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst),
        .fq    (bus)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_empty_cyc (stat_empty_cyc),
        .stat_redirects (stat_redirects)
`endif
    );

    always #5 clk = ~clk;

    // Memory-side bookkeeping: accepted requests awaiting their response.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;
    vec_t vecs[4];

    int total = 0, bad = 0, cyc = 0, lat = 1, epoch = 0, queued = 0, pops = 0;
    int n_empty = 0, n_redir = 0;
    bit rand_ready = 1'b0;
    logic redir = 1'b0, drdy = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] exp_pc = RESET_PC, fetch_exp = RESET_PC, last_pop_pc = '0;

    function automatic logic [31:0] image(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check and update the reference model, advance.
    task automatic tick();
        pend_t r, q;
        logic  have_rsp, exp_req;
        @(negedge clk);
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        bus.dec_ready      = drdy;
        bus.imem_req_ready = rst ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        have_rsp           = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.imem_rsp_valid = have_rsp;
        bus.imem_rsp_data  = have_rsp ? image(pend[0].addr) : $urandom();
        #1;
        if (rst) begin
            chk("req_valid_in_reset", 32'(bus.imem_req_valid), 32'h0);
        end else begin
            exp_req = !redir && (pend.size() < MAX_OUTS) && (queued + pend.size() < DEPTH);
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            chk("dec_valid", 32'(bus.dec_valid), 32'(queued != 0));
            if (drdy && !bus.dec_valid) n_empty++;
            if (redir) n_redir++;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_addr", bus.imem_req_addr, fetch_exp);
                q.addr  = bus.imem_req_addr;
                q.due   = cyc + lat;
                q.epoch = epoch;
                pend.push_back(q);
                fetch_exp += 32'd4;
            end
            if (bus.dec_valid && drdy) begin
                chk("dec_pc", bus.dec_pc, exp_pc);
                chk("dec_instr", bus.dec_instr, image(exp_pc));
                last_pop_pc = bus.dec_pc;
                exp_pc += 32'd4;
                pops++;
                if (queued > 0) queued--;
            end
        end
        if (have_rsp) begin
            r = pend.pop_front();
            if (!rst && (r.epoch == epoch) && !redir) queued++;
        end
        if (!rst && redir) begin
            queued    = 0;
            epoch++;
            exp_pc    = redir_pc & ~32'h3;
            fetch_exp = exp_pc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        redir = 1'b0;
        repeat (n) tick();
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
        chk("rst_dec_pc", bus.dec_pc, 32'h0);
        chk("rst_dec_instr", bus.dec_instr, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("rst_stat_empty", stat_empty_cyc, 32'h0);
        chk("rst_stat_redir", stat_redirects, 32'h0);
`endif
        pend.delete();
        rst       = 1'b0;
        queued    = 0;
        epoch++;
        exp_pc    = RESET_PC;
        fetch_exp = RESET_PC;
        n_empty   = 0;
        n_redir   = 0;
    endtask

    task automatic wait_pop(input string name);
        int p0 = pops;
        int n  = 0;
        while (pops == p0 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (pops == p0) begin
            bad++;
            $display("FAIL %s: got 0 instructions in 50 cycles want 1", name);
        end
    endtask

    task automatic wait_outs2();
        int n = 0;
        while (pend.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("two_outstanding", 32'(pend.size()), 32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int p0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;

        vecs[0] = '{rpc: 32'h0000_0102, pc0: 32'h0000_0100, pc1: 32'h0000_0104};
        vecs[1] = '{rpc: 32'hFFFF_FFFE, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000};
        vecs[2] = '{rpc: 32'h0000_0203, pc0: 32'h0000_0200, pc1: 32'h0000_0204};
        vecs[3] = '{rpc: 32'h7FFF_FFF9, pc0: 32'h7FFF_FFF8, pc1: 32'h7FFF_FFFC};

        // Sequential stream at latency 1, consumer always ready.
        lat  = 1;
        drdy = 1'b1;
        do_reset(3);
        repeat (4) tick();
        p0 = pops;
        repeat (12) tick();
        chk("t1_full_rate_pops", 32'(pops - p0), 32'd12);

        // Consumer stalls: queue fills to DEPTH, requests stop, then drains back to back.
        drdy = 1'b0;
        repeat (10) tick();
        chk("t2_req_idle_when_full", 32'(bus.imem_req_valid), 32'h0);
        chk("t2_dec_valid_held", 32'(bus.dec_valid), 32'h1);
        drdy = 1'b1;
        p0   = pops;
        repeat (DEPTH) tick();
        chk("t2_buffered_drain", 32'(pops - p0), DEPTH);

        // Latency 3 with two requests in flight, then redirect.
        lat = 3;
        wait_outs2();
        redir    = 1'b1;
        redir_pc = 32'h100;
        tick();
        redir = 1'b0;
        wait_pop("t3_wait");
        chk("t3_first_pc", last_pop_pc, 32'h100);

        // Redirect in a cycle with response and pop, then again next cycle.
        lat = 1;
        repeat (6) tick();
        redir    = 1'b1;
        redir_pc = 32'h180;
        tick();
        redir_pc = 32'h200;
        tick();
        redir = 1'b0;
        wait_pop("t4_wait");
        chk("t4_last_redirect_wins", last_pop_pc, 32'h200);

        // Alignment and address wrap.
        for (int i = 0; i < 4; i++) begin
            redir    = 1'b1;
            redir_pc = vecs[i].rpc;
            tick();
            redir = 1'b0;
            wait_pop($sformatf("t5_wait0[%0d]", i));
            chk($sformatf("t5_pc0[%0d]", i), last_pop_pc, vecs[i].pc0);
            wait_pop($sformatf("t5_wait1[%0d]", i));
            chk($sformatf("t5_pc1[%0d]", i), last_pop_pc, vecs[i].pc1);
        end

`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_redirects", stat_redirects, 32'(n_redir));
        chk("stat_empty_cyc", stat_empty_cyc, 32'(n_empty));
`endif

        // Reset with requests outstanding; late responses fall inside reset.
        lat = 3;
        wait_outs2();
        do_reset(lat + 2);
        wait_pop("t6_wait");
        chk("t6_first_pc", last_pop_pc, RESET_PC);

        // Randomized traffic against the reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) lat = $urandom_range(1, 4);
            drdy     = ($urandom_range(0, 3) != 0);
            redir    = ($urandom_range(0, 19) == 0);
            redir_pc = $urandom();
            tick();
        end
        redir      = 1'b0;
        drdy       = 1'b1;
        rand_ready = 1'b0;
        wait_pop("rand_drain");

`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_redirects_end", stat_redirects, 32'(n_redir));
        chk("stat_empty_cyc_end", stat_empty_cyc, 32'(n_empty));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
